branch_predictor: RTL and testbench

// - Parametrised BTB + 2-bit bimodal predictor for the 5-stage RV32I pipeline; closes the branch-prediction TODO.
// - IF presents the fetch PC and gets a same-cycle taken/target guess. EX reports each resolved branch/jump back.
// - Replaces the current always-stall-on-branch policy.

---
 rtl/branch_predictor.sv | 129 ++++++++++++
 tb/tb_branch_predictor.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor
// Direct-mapped branch target buffer with a 2-bit bimodal counter per entry.
// IF gets a same-cycle taken/target guess for its fetch PC. EX writes each
// resolved branch or jump back into the table on the clock edge.
// Optional feature macro: BP_STATS_EN adds resolved-update and mispredict
// counters on the stat_lookups / stat_mispred ports.
module branch_predictor #(
   parameter  int unsigned DATA_LEN = 32,
   parameter  int unsigned ENTRIES  = 16,
   localparam int unsigned IDX_LEN  = $clog2(ENTRIES),
   localparam int unsigned TAG_LEN  = DATA_LEN - IDX_LEN - 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DATA_LEN-1:0] if_pc,
   output logic                pred_taken,
   output logic [DATA_LEN-1:0] pred_target,
   input  logic                flush,
   input  logic                upd_valid,
   input  logic [DATA_LEN-1:0] upd_pc,
   input  logic                upd_is_jal,
   input  logic                upd_taken,
   input  logic [DATA_LEN-1:0] upd_target,
   input  logic                upd_pred_taken,
   input  logic [DATA_LEN-1:0] upd_pred_target
`ifdef BP_STATS_EN
   ,
   output logic [31:0]         stat_lookups,
   output logic [31:0]         stat_mispred
`endif
);

   logic                valid_q  [ENTRIES];
   logic [TAG_LEN-1:0]  tag_q    [ENTRIES];
   logic [1:0]          ctr_q    [ENTRIES];
   logic [DATA_LEN-1:0] target_q [ENTRIES];

   logic [IDX_LEN-1:0]  lk_idx;
   logic [TAG_LEN-1:0]  lk_tag;
   logic                lk_hit;
   logic [IDX_LEN-1:0]  up_idx;
   logic [TAG_LEN-1:0]  up_tag;
   logic                up_hit;
   logic [1:0]          ctr_next;
   logic                unused_bits;

   // The two low PC bits never select anything; without stats the predicted
   // values carried down the pipe are not needed either.
`ifdef BP_STATS_EN
   assign unused_bits = ^{if_pc[1:0], upd_pc[1:0]};
`else
   assign unused_bits = ^{if_pc[1:0], upd_pc[1:0], upd_pred_taken, upd_pred_target};
`endif

   assign lk_idx = if_pc[IDX_LEN+1:2];
   assign lk_tag = if_pc[DATA_LEN-1:IDX_LEN+2];
   assign up_idx = upd_pc[IDX_LEN+1:2];
   assign up_tag = upd_pc[DATA_LEN-1:IDX_LEN+2];

   // Lookup reads the registered table, so a same-cycle update is not seen.
   always_comb begin
      lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_taken  = !reset && lk_hit && ctr_q[lk_idx][1];
      pred_target = pred_taken ? target_q[lk_idx] : '0;
   end

   // Next counter value for an update that hits: JAL forces strongly taken,
   // and branches saturate at 00 and 11.
   always_comb begin
      up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
      ctr_next = ctr_q[up_idx];
      if (upd_is_jal) begin
         ctr_next = 2'b11;
      end else if (upd_taken) begin
         if (ctr_q[up_idx] != 2'b11) ctr_next = ctr_q[up_idx] + 2'd1;
      end else begin
         if (ctr_q[up_idx] != 2'b00) ctr_next = ctr_q[up_idx] - 2'd1;
      end
   end

   // Table state: flush only clears valid bits and drops any update in the same
   // cycle. A taken miss allocates the entry, and a not-taken miss changes nothing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            ctr_q[i]    <= 2'b01;
            target_q[i] <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            valid_q[i] <= 1'b0;
         end
      end else if (upd_valid) begin
         if (up_hit) begin
            ctr_q[up_idx] <= ctr_next;
            if (upd_taken) target_q[up_idx] <= upd_target;
         end else if (upd_taken) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= upd_target;
            ctr_q[up_idx]    <= upd_is_jal ? 2'b11 : 2'b10;
         end
      end
   end

`ifdef BP_STATS_EN
   logic mispred;

   // A mispredict is either a wrong direction or a taken/taken pair whose targets differ.
   always_comb begin
      mispred = (upd_taken != upd_pred_taken) ||
                (upd_taken && upd_pred_taken && (upd_target != upd_pred_target));
   end

   // The counters wrap naturally. Updates dropped by flush are not counted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_lookups <= '0;
         stat_mispred <= '0;
      end else if (upd_valid && !flush) begin
         stat_lookups <= stat_lookups + 32'd1;
         if (mispred) stat_mispred <= stat_mispred + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
// Directed test of branch_predictor (ENTRIES=16). The stats scenario only runs
// when BP_STATS_EN is defined.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        flush;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_is_jal;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;
`ifdef BP_STATS_EN
   logic [31:0] stat_lookups;
   logic [31:0] stat_mispred;
`endif

   int checks = 0;
   int errors = 0;

   branch_predictor #(.DATA_LEN(32), .ENTRIES(16)) dut (
      .clk             (clk),
      .reset           (reset),
      .if_pc           (if_pc),
      .pred_taken      (pred_taken),
      .pred_target     (pred_target),
      .flush           (flush),
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_is_jal      (upd_is_jal),
      .upd_taken       (upd_taken),
      .upd_target      (upd_target),
      .upd_pred_taken  (upd_pred_taken),
      .upd_pred_target (upd_pred_target)
`ifdef BP_STATS_EN
      ,
      .stat_lookups    (stat_lookups),
      .stat_mispred    (stat_mispred)
`endif
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // One resolved update, driven at the negedge and committed on the next posedge.
   task automatic do_update(input logic [31:0] pc, input logic jal, input logic taken,
                            input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
      @(negedge clk);
      upd_valid       = 1'b1;
      upd_pc          = pc;
      upd_is_jal      = jal;
      upd_taken       = taken;
      upd_target      = tgt;
      upd_pred_taken  = ptaken;
      upd_pred_target = ptgt;
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
   endtask

   // Reset state: every index misses, and both outputs are zero.
   task automatic test_reset();
      reset = 1'b1;
      flush = 1'b0;
      upd_valid = 1'b0;
      upd_pc = '0;
      upd_is_jal = 1'b0;
      upd_taken = 1'b0;
      upd_target = '0;
      upd_pred_taken = 1'b0;
      upd_pred_target = '0;
      if_pc = 32'h40;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({pred_taken, pred_target} !== {1'b0, 32'h0}) begin
         errors++;
         $display("[TB] FAIL reset_0x40: got %b/%h expected 0/00000000", pred_taken, pred_target);
      end
`ifdef BP_STATS_EN
      checks++;
      if ({stat_lookups, stat_mispred} !== 64'h0) begin
         errors++;
         $display("[TB] FAIL reset_stats: got %0d/%0d expected 0/0", stat_lookups, stat_mispred);
      end
`endif
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if_pc = 32'(i) * 32'd4;
         #1;
         checks++;
         if ({pred_taken, pred_target} !== {1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL reset_idx%0d: got %b/%h expected 0/00000000", i, pred_taken, pred_target);
         end
      end
   endtask

   // A taken branch allocates. The same index with a different tag misses.
   task automatic test_allocate();
      do_update(32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
      if_pc = 32'h40;
      #1;
      checks++;
      if ({pred_taken, pred_target} !== {1'b1, 32'h80}) begin
         errors++;
         $display("[TB] FAIL alloc_hit: got %b/%h expected 1/00000080", pred_taken, pred_target);
      end
      if_pc = 32'h440;
      #1;
      checks++;
      if ({pred_taken, pred_target} !== {1'b0, 32'h0}) begin
         errors++;
         $display("[TB] FAIL alloc_alias: got %b/%h expected 0/00000000", pred_taken, pred_target);
      end
   endtask

   // Counter walk on 0x40, starting from 10. The last taken update moves the target.
   task automatic test_hysteresis();
      logic        tk   [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [31:0] tg   [8] = '{32'h0, 32'h80, 32'h80, 32'h80, 32'h80, 32'h0, 32'h0, 32'hA0};
      logic        ep   [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [31:0] et   [8] = '{32'h0, 32'h80, 32'h80, 32'h80, 32'h80, 32'h80, 32'h0, 32'hA0};
      for (int i = 0; i < 8; i++) begin
         do_update(32'h40, 1'b0, tk[i], tg[i], 1'b0, 32'h0);
         if_pc = 32'h40;
         #1;
         checks++;
         if ({pred_taken, pred_target} !== {ep[i], et[i]}) begin
            errors++;
            $display("[TB] FAIL hyst_step%0d: got %b/%h expected %b/%h", i, pred_taken, pred_target, ep[i], et[i]);
         end
      end
   endtask

   // JAL allocates strongly taken. A branch not-taken miss does not allocate.
   task automatic test_jal();
      logic [31:0] pcs [6] = '{32'h100, 32'h40, 32'h100, 32'h100, 32'h100, 32'h100};
      logic        ep  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [31:0] et  [6] = '{32'h200, 32'h0, 32'h200, 32'h0, 32'h200, 32'h200};
      // step0: JAL alloc (11). step1: old 0x40 evicted. step2: branch nt gives 10.
      // step3: nt gives 01. step4: JAL hit gives 11. step5: nt gives 10.
      for (int i = 0; i < 6; i++) begin
         case (i)
            0:       do_update(32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
            2, 3, 5: do_update(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            4:       do_update(32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
            default: ;
         endcase
         if_pc = pcs[i];
         #1;
         checks++;
         if ({pred_taken, pred_target} !== {ep[i], et[i]}) begin
            errors++;
            $display("[TB] FAIL jal_step%0d: got %b/%h expected %b/%h", i, pred_taken, pred_target, ep[i], et[i]);
         end
      end
      do_update(32'h104, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      if_pc = 32'h104;
      #1;
      checks++;
      if ({pred_taken, pred_target} !== {1'b0, 32'h0}) begin
         errors++;
         $display("[TB] FAIL nt_miss_noalloc: got %b/%h expected 0/00000000", pred_taken, pred_target);
      end
   endtask

   // A lookup during an update at the same index sees the old entry.
   task automatic test_read_during_write();
      do_update(32'h48, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
      @(negedge clk);
      upd_valid  = 1'b1;
      upd_pc     = 32'h48;
      upd_is_jal = 1'b0;
      upd_taken  = 1'b0;
      upd_target = 32'h0;
      if_pc      = 32'h48;
      #1;
      checks++;
      if ({pred_taken, pred_target} !== {1'b1, 32'h300}) begin
         errors++;
         $display("[TB] FAIL rdw_old: got %b/%h expected 1/00000300", pred_taken, pred_target);
      end
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      checks++;
      if ({pred_taken, pred_target} !== {1'b0, 32'h0}) begin
         errors++;
         $display("[TB] FAIL rdw_new: got %b/%h expected 0/00000000", pred_taken, pred_target);
      end
   endtask

   // flush with an update in the same cycle: all entries invalid, update dropped.
   task automatic test_flush();
      logic [31:0] pcs [3] = '{32'h100, 32'h4C, 32'h48};
      if_pc = 32'h100;
      #1;
      checks++;
      if ({pred_taken, pred_target} !== {1'b1, 32'h200}) begin
         errors++;
         $display("[TB] FAIL flush_pre: got %b/%h expected 1/00000200", pred_taken, pred_target);
      end
      @(negedge clk);
      flush      = 1'b1;
      upd_valid  = 1'b1;
      upd_pc     = 32'h4C;
      upd_is_jal = 1'b0;
      upd_taken  = 1'b1;
      upd_target = 32'h400;
      @(posedge clk);
      #1;
      flush     = 1'b0;
      upd_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if_pc = pcs[i];
         #1;
         checks++;
         if ({pred_taken, pred_target} !== {1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL flush_miss%0d: got %b/%h expected 0/00000000", i, pred_taken, pred_target);
         end
      end
   endtask

   // Updates on consecutive cycles, including two to the same entry.
   task automatic test_back_to_back();
      do_update(32'h60, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0);
      do_update(32'h64, 1'b1, 1'b1, 32'h640, 1'b0, 32'h0);
      do_update(32'h60, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      if_pc = 32'h60;
      #1;
      checks++;
      if ({pred_taken, pred_target} !== {1'b0, 32'h0}) begin
         errors++;
         $display("[TB] FAIL b2b_0x60: got %b/%h expected 0/00000000", pred_taken, pred_target);
      end
      if_pc = 32'h64;
      #1;
      checks++;
      if ({pred_taken, pred_target} !== {1'b1, 32'h640}) begin
         errors++;
         $display("[TB] FAIL b2b_0x64: got %b/%h expected 1/00000640", pred_taken, pred_target);
      end
   endtask

`ifdef BP_STATS_EN
   // Counts with one wrong direction and one wrong target, then flush drop and async reset.
   task automatic test_stats();
      @(negedge clk);
      reset = 1'b1;
      #1;
      reset = 1'b0;
      do_update(32'h70, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0);
      do_update(32'h74, 1'b0, 1'b1, 32'h700, 1'b1, 32'h700);
      do_update(32'h78, 1'b0, 1'b1, 32'h780, 1'b0, 32'h0);
      do_update(32'h7C, 1'b1, 1'b1, 32'h7C0, 1'b1, 32'h7D0);
      checks++;
      if ({stat_lookups, stat_mispred} !== {32'd4, 32'd2}) begin
         errors++;
         $display("[TB] FAIL stats_count: got %0d/%0d expected 4/2", stat_lookups, stat_mispred);
      end
      @(negedge clk);
      flush          = 1'b1;
      upd_valid      = 1'b1;
      upd_pc         = 32'h70;
      upd_taken      = 1'b1;
      upd_pred_taken = 1'b0;
      @(posedge clk);
      #1;
      flush     = 1'b0;
      upd_valid = 1'b0;
      checks++;
      if ({stat_lookups, stat_mispred} !== {32'd4, 32'd2}) begin
         errors++;
         $display("[TB] FAIL stats_flush_drop: got %0d/%0d expected 4/2", stat_lookups, stat_mispred);
      end
      do_update(32'h74, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0);
      @(negedge clk);
      upd_valid = 1'b1;
      upd_pc    = 32'h74;
      upd_taken = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      if_pc = 32'h74;
      checks++;
      if ({stat_lookups, stat_mispred} !== 64'h0) begin
         errors++;
         $display("[TB] FAIL stats_async_reset: got %0d/%0d expected 0/0", stat_lookups, stat_mispred);
      end
      #1;
      checks++;
      if ({pred_taken, pred_target} !== {1'b0, 32'h0}) begin
         errors++;
         $display("[TB] FAIL reset_mid_update_pred: got %b/%h expected 0/00000000", pred_taken, pred_target);
      end
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if ({stat_lookups, stat_mispred} !== 64'h0) begin
         errors++;
         $display("[TB] FAIL stats_after_reset: got %0d/%0d expected 0/0", stat_lookups, stat_mispred);
      end
   endtask
`endif

   // Test sequence
   initial begin
      test_reset();
      test_allocate();
      test_hysteresis();
      test_jal();
      test_read_during_write();
      test_flush();
      test_back_to_back();
`ifdef BP_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
